// File: rtl/regbank_arbiter.sv
// Two-port round-robin arbiter sharing one register bank between the UART
// host (port A) and the I2C host (port B). Each port owns a one-entry pending
// slot; slots are serialised onto the bank, and read data returns with a pulse.
module regbank_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              a_reg_en,
  input  logic              a_write_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_busy,
  output logic              a_overflow,
  input  logic              b_reg_en,
  input  logic              b_write_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              b_busy,
  output logic              b_overflow,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              bank_reg_en,
  output logic              bank_write_en,
  input  logic [DATA_W-1:0] bank_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  state_t            state, state_next;
  port_t             last_grant, last_grant_next;
  port_t             winner, winner_next;
  logic              cur_we, cur_we_next;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_next;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_next;

  logic              a_pend, a_pend_next, b_pend, b_pend_next;
  slot_t             a_slot, a_slot_next, b_slot, b_slot_next;
  logic              a_overflow_next, b_overflow_next;
  logic              a_busy_next, b_busy_next;
  logic [DATA_W-1:0] a_rdata_next, b_rdata_next;
  logic              a_rvalid_next, b_rvalid_next;
  logic [ADDR_W-1:0] bank_addr_next;
  logic [DATA_W-1:0] bank_wdata_next;
  logic              bank_reg_en_next, bank_write_en_next;

  logic              a_locked, b_locked, a_blocked, b_blocked, timed_out;
  logic              grant_valid;
  port_t             grant;
  slot_t             sel_slot;
  logic              other_pend;

  // Winner selection: round robin, overridden by the current owner's lock until timeout
  always_comb begin
    a_locked    = a_lock && (last_grant == PORT_A);
    b_locked    = b_lock && (last_grant == PORT_B);
    timed_out   = (lock_cnt == CNT_W'(LOCK_TIMEOUT));
    a_blocked   = b_locked && !timed_out;
    b_blocked   = a_locked && !timed_out;
    other_pend  = (last_grant == PORT_A) ? b_pend : a_pend;
    grant_valid = 1'b0;
    grant       = PORT_A;
    if (state == ST_IDLE) begin
      if (a_pend && !a_blocked && (!b_pend || b_blocked || (last_grant == PORT_B))) begin
        grant_valid = 1'b1;
        grant       = PORT_A;
      end else if (b_pend && !b_blocked) begin
        grant_valid = 1'b1;
        grant       = PORT_B;
      end
    end
    sel_slot = (grant == PORT_A) ? a_slot : b_slot;
  end

  // Next-state, bank drive, read return and lock counter
  always_comb begin
    state_next         = state;
    last_grant_next    = last_grant;
    winner_next        = winner;
    cur_we_next        = cur_we;
    lat_cnt_next       = lat_cnt;
    lock_cnt_next      = lock_cnt;
    bank_addr_next     = bank_addr;
    bank_wdata_next    = bank_wdata;
    bank_reg_en_next   = 1'b0;
    bank_write_en_next = 1'b0;
    a_rdata_next       = a_rdata;
    b_rdata_next       = b_rdata;
    a_rvalid_next      = 1'b0;
    b_rvalid_next      = 1'b0;

    if (!(a_locked || b_locked)) begin
      lock_cnt_next = '0;
    end else if (grant_valid && (grant != last_grant)) begin
      lock_cnt_next = '0;
    end else if ((state == ST_IDLE) && other_pend) begin
      lock_cnt_next = lock_cnt + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          winner_next        = grant;
          last_grant_next    = grant;
          cur_we_next        = sel_slot.we;
          bank_addr_next     = sel_slot.addr;
          bank_wdata_next    = sel_slot.wdata;
          bank_reg_en_next   = 1'b1;
          bank_write_en_next = sel_slot.we;
          state_next         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_next = '0;
        state_next   = cur_we ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
          state_next = ST_RETURN;
          if (winner == PORT_A) begin
            a_rdata_next  = bank_rdata;
            a_rvalid_next = 1'b1;
          end else begin
            b_rdata_next  = bank_rdata;
            b_rvalid_next = 1'b1;
          end
        end else begin
          lat_cnt_next = lat_cnt + LAT_W'(1);
        end
      end
      ST_RETURN: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Pending slots: capture strobes, drain on grant, flag drops, derive busy
  always_comb begin
    a_pend_next     = a_pend && !(grant_valid && (grant == PORT_A));
    b_pend_next     = b_pend && !(grant_valid && (grant == PORT_B));
    a_slot_next     = a_slot;
    b_slot_next     = b_slot;
    a_overflow_next = a_overflow;
    b_overflow_next = b_overflow;
    if (a_reg_en) begin
      if (a_pend_next) begin
        a_overflow_next = 1'b1;
      end else begin
        a_pend_next = 1'b1;
        a_slot_next = '{we: a_write_en, addr: a_addr, wdata: a_wdata};
      end
    end
    if (b_reg_en) begin
      if (b_pend_next) begin
        b_overflow_next = 1'b1;
      end else begin
        b_pend_next = 1'b1;
        b_slot_next = '{we: b_write_en, addr: b_addr, wdata: b_wdata};
      end
    end
    a_busy_next = a_pend_next || ((state_next != ST_IDLE) && (winner_next == PORT_A));
    b_busy_next = b_pend_next || ((state_next != ST_IDLE) && (winner_next == PORT_B));
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state         <= ST_IDLE;
      last_grant    <= PORT_B;
      winner        <= PORT_A;
      cur_we        <= 1'b0;
      lat_cnt       <= '0;
      lock_cnt      <= '0;
      a_pend        <= 1'b0;
      b_pend        <= 1'b0;
      a_slot        <= '0;
      b_slot        <= '0;
      a_rdata       <= '0;
      a_rvalid      <= 1'b0;
      a_busy        <= 1'b0;
      a_overflow    <= 1'b0;
      b_rdata       <= '0;
      b_rvalid      <= 1'b0;
      b_busy        <= 1'b0;
      b_overflow    <= 1'b0;
      bank_addr     <= '0;
      bank_wdata    <= '0;
      bank_reg_en   <= 1'b0;
      bank_write_en <= 1'b0;
    end else begin
      state         <= state_next;
      last_grant    <= last_grant_next;
      winner        <= winner_next;
      cur_we        <= cur_we_next;
      lat_cnt       <= lat_cnt_next;
      lock_cnt      <= lock_cnt_next;
      a_pend        <= a_pend_next;
      b_pend        <= b_pend_next;
      a_slot        <= a_slot_next;
      b_slot        <= b_slot_next;
      a_rdata       <= a_rdata_next;
      a_rvalid      <= a_rvalid_next;
      a_busy        <= a_busy_next;
      a_overflow    <= a_overflow_next;
      b_rdata       <= b_rdata_next;
      b_rvalid      <= b_rvalid_next;
      b_busy        <= b_busy_next;
      b_overflow    <= b_overflow_next;
      bank_addr     <= bank_addr_next;
      bank_wdata    <= bank_wdata_next;
      bank_reg_en   <= bank_reg_en_next;
      bank_write_en <= bank_write_en_next;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: two instances (default lock timeout
// and a short one) share stimulus; monitors check bank traffic and read returns.
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       resetb;
  logic       a_reg_en, a_write_en, a_lock, b_reg_en, b_write_en, b_lock;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       bank_preload;

  logic [7:0] a_rdata_1, b_rdata_1, bank_addr_1, bank_wdata_1, bank_rdata_1;
  logic       a_rvalid_1, a_busy_1, a_overflow_1, b_rvalid_1, b_busy_1, b_overflow_1;
  logic       bank_reg_en_1, bank_write_en_1;
  logic [7:0] a_rdata_4, b_rdata_4, bank_addr_4, bank_wdata_4, bank_rdata_4;
  logic       a_rvalid_4, a_busy_4, a_overflow_4, b_rvalid_4, b_busy_4, b_overflow_4;
  logic       bank_reg_en_4, bank_write_en_4;

  logic [7:0] mem1 [256];
  logic [7:0] mem4 [256];

  int n_checks = 0;
  int n_fail   = 0;
  logic mon1_en = 1'b1;
  logic mon4_en = 1'b0;

  logic [31:0] exp_bank1[$];
  logic [31:0] exp_bank4[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  always #5 clk = ~clk;

  regbank_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .LOCK_TIMEOUT(1024)) u_dut (
    .clk(clk), .resetb(resetb),
    .a_reg_en(a_reg_en), .a_write_en(a_write_en), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_lock(a_lock), .a_rdata(a_rdata_1), .a_rvalid(a_rvalid_1), .a_busy(a_busy_1),
    .a_overflow(a_overflow_1),
    .b_reg_en(b_reg_en), .b_write_en(b_write_en), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_rdata(b_rdata_1), .b_rvalid(b_rvalid_1), .b_busy(b_busy_1),
    .b_overflow(b_overflow_1),
    .bank_addr(bank_addr_1), .bank_wdata(bank_wdata_1), .bank_reg_en(bank_reg_en_1),
    .bank_write_en(bank_write_en_1), .bank_rdata(bank_rdata_1)
  );

  regbank_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .LOCK_TIMEOUT(4)) u_dut4 (
    .clk(clk), .resetb(resetb),
    .a_reg_en(a_reg_en), .a_write_en(a_write_en), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_lock(a_lock), .a_rdata(a_rdata_4), .a_rvalid(a_rvalid_4), .a_busy(a_busy_4),
    .a_overflow(a_overflow_4),
    .b_reg_en(b_reg_en), .b_write_en(b_write_en), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_rdata(b_rdata_4), .b_rvalid(b_rvalid_4), .b_busy(b_busy_4),
    .b_overflow(b_overflow_4),
    .bank_addr(bank_addr_4), .bank_wdata(bank_wdata_4), .bank_reg_en(bank_reg_en_4),
    .bank_write_en(bank_write_en_4), .bank_rdata(bank_rdata_4)
  );

  // Register bank models, one-cycle read latency
  always @(posedge clk) begin
    if (bank_preload) begin
      mem1[8'h10] <= 8'h5A;
      mem1[8'h40] <= 8'hC3;
    end else if (bank_reg_en_1) begin
      if (bank_write_en_1) mem1[bank_addr_1] <= bank_wdata_1;
      bank_rdata_1 <= mem1[bank_addr_1];
    end
  end

  always @(posedge clk) begin
    if (bank_preload) begin
      mem4[8'h10] <= 8'h5A;
      mem4[8'h40] <= 8'hC3;
    end else if (bank_reg_en_4) begin
      if (bank_write_en_4) mem4[bank_addr_4] <= bank_wdata_4;
      bank_rdata_4 <= mem4[bank_addr_4];
    end
  end

  function automatic logic [31:0] txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    return {15'd0, we, addr, wdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
  endtask

  // Monitor: pop and compare whenever an instance presents bank traffic or read data
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon1_en) begin
      if (bank_reg_en_1) begin
        if (exp_bank1.size() == 0) unexpected("bank1_txn", txn(bank_write_en_1, bank_addr_1, bank_wdata_1));
        else begin
          e = exp_bank1.pop_front();
          check("bank1_txn", txn(bank_write_en_1, bank_addr_1, bank_wdata_1), e);
        end
      end
      if (a_rvalid_1) begin
        if (exp_a.size() == 0) unexpected("a_read", 32'(a_rdata_1));
        else begin
          e = exp_a.pop_front();
          check("a_read", 32'(a_rdata_1), e);
        end
      end
      if (b_rvalid_1) begin
        if (exp_b.size() == 0) unexpected("b_read", 32'(b_rdata_1));
        else begin
          e = exp_b.pop_front();
          check("b_read", 32'(b_rdata_1), e);
        end
      end
    end
    if (mon4_en && bank_reg_en_4) begin
      if (exp_bank4.size() == 0) unexpected("bank4_txn", txn(bank_write_en_4, bank_addr_4, bank_wdata_4));
      else begin
        e = exp_bank4.pop_front();
        check("bank4_txn", txn(bank_write_en_4, bank_addr_4, bank_wdata_4), e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    a_reg_en = 1'b0; a_write_en = 1'b0;
    b_reg_en = 1'b0; b_write_en = 1'b0;
  endtask

  task automatic strobe_a(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    a_reg_en = 1'b1; a_write_en = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic strobe_b(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    b_reg_en = 1'b1; b_write_en = we; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    clear_strobes();
    a_lock = 1'b0; b_lock = 1'b0;
    cyc();
    cyc();
    resetb = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_bank_q_empty"}, 32'(exp_bank1.size()), 32'd0);
    check({tag, "_a_q_empty"}, 32'(exp_a.size()), 32'd0);
    check({tag, "_b_q_empty"}, 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    resetb = 1'b0; bank_preload = 1'b1;
    a_lock = 1'b0; b_lock = 1'b0;
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
    clear_strobes();
    cyc();
    cyc();
    bank_preload = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_a_out", {a_rdata_1, a_rvalid_1, a_busy_1, a_overflow_1}, 32'd0);
    check("rst_b_out", {b_rdata_1, b_rvalid_1, b_busy_1, b_overflow_1}, 32'd0);
    check("rst_bank_out", {bank_addr_1, bank_wdata_1, bank_reg_en_1, bank_write_en_1}, 32'd0);
    resetb = 1'b1;
    cyc();

    // Single read: strobe cycle 0, bank strobe cycle 2, rvalid cycle 4
    exp_bank1.push_back(txn(1'b0, 8'h10, 8'h00));
    exp_a.push_back(32'h5A);
    strobe_a(1'b0, 8'h10, 8'h00);
    cyc();
    clear_strobes();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("rd_busy_c%0d", c), 32'(a_busy_1), (c <= 4) ? 32'd1 : 32'd0);
      check($sformatf("rd_bank_en_c%0d", c), 32'(bank_reg_en_1), (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("rd_rvalid_c%0d", c), 32'(a_rvalid_1), (c == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    @(negedge clk);
    check("rd_rdata_held", 32'(a_rdata_1), 32'h5A);
    check_drained("rd");

    // Simultaneous writes: A first after reset, then round robin picks B on the next tie
    do_reset();
    exp_bank1.push_back(txn(1'b1, 8'h20, 8'h01));
    exp_bank1.push_back(txn(1'b1, 8'h30, 8'h02));
    exp_bank1.push_back(txn(1'b1, 8'h21, 8'h03));
    exp_bank1.push_back(txn(1'b1, 8'h31, 8'h04));
    exp_bank1.push_back(txn(1'b1, 8'h22, 8'h05));
    strobe_a(1'b1, 8'h20, 8'h01);
    strobe_b(1'b1, 8'h30, 8'h02);
    cyc();
    clear_strobes();
    repeat (4) cyc();
    strobe_a(1'b1, 8'h21, 8'h03);
    cyc();
    clear_strobes();
    repeat (2) cyc();
    strobe_a(1'b1, 8'h22, 8'h05);
    strobe_b(1'b1, 8'h31, 8'h04);
    cyc();
    clear_strobes();
    repeat (6) cyc();
    check_drained("rr");

    // Overflow: A strobes twice while B's read holds the bank
    do_reset();
    exp_bank1.push_back(txn(1'b0, 8'h40, 8'h00));
    exp_b.push_back(32'hC3);
    exp_bank1.push_back(txn(1'b1, 8'h50, 8'h55));
    strobe_b(1'b0, 8'h40, 8'h00);
    cyc();
    clear_strobes();
    cyc();
    strobe_a(1'b1, 8'h50, 8'h55);
    cyc();
    strobe_a(1'b1, 8'h51, 8'h66);
    cyc();
    clear_strobes();
    @(negedge clk);
    check("ovf_a_set", 32'(a_overflow_1), 32'd1);
    check("ovf_b_clear", 32'(b_overflow_1), 32'd0);
    repeat (6) cyc();
    @(negedge clk);
    check("ovf_a_sticky", 32'(a_overflow_1), 32'd1);
    check_drained("ovf");

    // Lock: A streams locked writes while B waits; short timeout lets B in after 4 blocked IDLEs
    do_reset();
    @(negedge clk);
    check("ovf_cleared_by_reset", 32'(a_overflow_1), 32'd0);
    mon4_en = 1'b1;
    for (int k = 1; k <= 6; k++) exp_bank1.push_back(txn(1'b1, 8'(8'h5F + k), 8'(8'hA0 + k)));
    exp_bank1.push_back(txn(1'b1, 8'h70, 8'hB0));
    for (int k = 1; k <= 5; k++) exp_bank4.push_back(txn(1'b1, 8'(8'h5F + k), 8'(8'hA0 + k)));
    exp_bank4.push_back(txn(1'b1, 8'h70, 8'hB0));
    exp_bank4.push_back(txn(1'b1, 8'h65, 8'hA6));
    cyc();
    for (int c = 0; c < 16; c++) begin
      clear_strobes();
      a_lock = (c < 14);
      if (c == 0) strobe_b(1'b1, 8'h70, 8'hB0);
      if ((c % 2 == 0) && (c <= 10)) strobe_a(1'b1, 8'(8'h60 + c / 2), 8'(8'hA1 + c / 2));
      if (c == 12) begin
        @(negedge clk);
        check("lock_b_busy_blocked", 32'(b_busy_1), 32'd1);
      end
      cyc();
    end
    clear_strobes();
    a_lock = 1'b0;
    repeat (4) cyc();
    check("lock_bank4_q_empty", 32'(exp_bank4.size()), 32'd0);
    check("lock_no_overflow", {30'd0, a_overflow_1, a_overflow_4}, 32'd0);
    check_drained("lock");
    mon4_en = 1'b0;

    // Reset during WAIT aborts the read with no rvalid
    do_reset();
    exp_bank1.push_back(txn(1'b0, 8'h10, 8'h00));
    strobe_a(1'b0, 8'h10, 8'h00);
    cyc();
    clear_strobes();
    cyc();
    cyc();
    resetb = 1'b0;
    cyc();
    resetb = 1'b1;
    @(negedge clk);
    check("rstmid_a_out", {a_rdata_1, a_rvalid_1, a_busy_1, a_overflow_1}, 32'd0);
    check("rstmid_bank_out", {bank_addr_1, bank_wdata_1, bank_reg_en_1, bank_write_en_1}, 32'd0);
    cyc();
    exp_bank1.push_back(txn(1'b0, 8'h40, 8'h00));
    exp_a.push_back(32'hC3);
    strobe_a(1'b0, 8'h40, 8'h00);
    cyc();
    clear_strobes();
    repeat (6) cyc();
    check_drained("rstmid");

    // Drain-and-capture: B re-strobes in the cycle its slot is granted
    do_reset();
    exp_bank1.push_back(txn(1'b1, 8'h80, 8'h11));
    exp_bank1.push_back(txn(1'b1, 8'h81, 8'h22));
    exp_bank1.push_back(txn(1'b0, 8'h81, 8'h00));
    exp_b.push_back(32'h22);
    strobe_b(1'b1, 8'h80, 8'h11);
    cyc();
    strobe_b(1'b1, 8'h81, 8'h22);
    cyc();
    clear_strobes();
    @(negedge clk);
    check("drain_no_overflow", 32'(b_overflow_1), 32'd0);
    check("drain_b_busy", 32'(b_busy_1), 32'd1);
    cyc();
    cyc();
    strobe_b(1'b0, 8'h81, 8'h00);
    cyc();
    clear_strobes();
    repeat (8) cyc();
    check("drain_overflow_final", 32'(b_overflow_1), 32'd0);
    check_drained("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
